falu_cmd_responder: RTL and testbench

//  Responder side of the FALU command interface: accepts one FP op per request over valid/ready,

---
 rtl/falu_pkg.sv | 37 +++
 rtl/falu_result_mux.sv | 50 +++++
 rtl/falu_cmd_responder.sv | 184 ++++++++++++++++++
 tb/tb_falu_cmd_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/falu_pkg.sv
// Shared constants for the FALU command responder: function codes, FSM states, widths.
package falu_pkg;

    localparam int unsigned FUNC_W = 5;
    localparam int unsigned RSP_W  = 64;
    localparam int unsigned CLS_W  = 10;
    localparam int unsigned CNT_W  = 4;

    localparam logic [FUNC_W-1:0] FUNC_FMADD   = 5'd0;
    localparam logic [FUNC_W-1:0] FUNC_FNMADD  = 5'd1;
    localparam logic [FUNC_W-1:0] FUNC_FMSUB   = 5'd2;
    localparam logic [FUNC_W-1:0] FUNC_FNMSUB  = 5'd3;
    localparam logic [FUNC_W-1:0] FUNC_ADD     = 5'd4;
    localparam logic [FUNC_W-1:0] FUNC_SUB     = 5'd5;
    localparam logic [FUNC_W-1:0] FUNC_MUL     = 5'd6;
    localparam logic [FUNC_W-1:0] FUNC_DIV     = 5'd7;
    localparam logic [FUNC_W-1:0] FUNC_FSQRT   = 5'd8;
    localparam logic [FUNC_W-1:0] FUNC_FSGNJ   = 5'd9;
    localparam logic [FUNC_W-1:0] FUNC_FSGNJN  = 5'd10;
    localparam logic [FUNC_W-1:0] FUNC_FSGNJX  = 5'd11;
    localparam logic [FUNC_W-1:0] FUNC_MIN_MAX = 5'd12;
    localparam logic [FUNC_W-1:0] FUNC_CLASS   = 5'd13;
    localparam logic [FUNC_W-1:0] FUNC_FMV_X_W = 5'd14;
    localparam logic [FUNC_W-1:0] FUNC_FMV_W_X = 5'd15;
    localparam logic [FUNC_W-1:0] FUNC_LAST    = 5'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic func_is_legal(input logic [FUNC_W-1:0] func);
        return func <= FUNC_LAST;
    endfunction

endpackage

// File: rtl/falu_result_mux.sv
// Selects the FALU result bus matching the captured function code, zero-extended to RSP_W.
module falu_result_mux
    import falu_pkg::*;
#(
    parameter int unsigned OP_W = 32
) (
    input  logic [FUNC_W-1:0] func_i,
    input  logic [OP_W-1:0]   out_fmadd_i,
    input  logic [OP_W-1:0]   out_fnmadd_i,
    input  logic [OP_W-1:0]   out_fmsub_i,
    input  logic [OP_W-1:0]   out_fnmsub_i,
    input  logic [OP_W-1:0]   out_add_i,
    input  logic [OP_W-1:0]   out_sub_i,
    input  logic [OP_W-1:0]   out_mul_i,
    input  logic [OP_W-1:0]   out_div_i,
    input  logic [OP_W-1:0]   out_fsqrt_i,
    input  logic [OP_W-1:0]   out_fsgnj_i,
    input  logic [OP_W-1:0]   out_fsgnjn_i,
    input  logic [OP_W-1:0]   out_fsgnjx_i,
    input  logic [OP_W-1:0]   out_min_max_i,
    input  logic [OP_W-1:0]   out_fmv_w_x_i,
    input  logic [CLS_W-1:0]  out_class_i,
    input  logic [RSP_W-1:0]  out_fmv_x_w_i,
    output logic [RSP_W-1:0]  sel_data_c
);

    always_comb begin
        sel_data_c = '0;
        case (func_i)
            FUNC_FMADD:   sel_data_c = RSP_W'(out_fmadd_i);
            FUNC_FNMADD:  sel_data_c = RSP_W'(out_fnmadd_i);
            FUNC_FMSUB:   sel_data_c = RSP_W'(out_fmsub_i);
            FUNC_FNMSUB:  sel_data_c = RSP_W'(out_fnmsub_i);
            FUNC_ADD:     sel_data_c = RSP_W'(out_add_i);
            FUNC_SUB:     sel_data_c = RSP_W'(out_sub_i);
            FUNC_MUL:     sel_data_c = RSP_W'(out_mul_i);
            FUNC_DIV:     sel_data_c = RSP_W'(out_div_i);
            FUNC_FSQRT:   sel_data_c = RSP_W'(out_fsqrt_i);
            FUNC_FSGNJ:   sel_data_c = RSP_W'(out_fsgnj_i);
            FUNC_FSGNJN:  sel_data_c = RSP_W'(out_fsgnjn_i);
            FUNC_FSGNJX:  sel_data_c = RSP_W'(out_fsgnjx_i);
            FUNC_MIN_MAX: sel_data_c = RSP_W'(out_min_max_i);
            FUNC_CLASS:   sel_data_c = RSP_W'(out_class_i);
            FUNC_FMV_X_W: sel_data_c = out_fmv_x_w_i;
            FUNC_FMV_W_X: sel_data_c = RSP_W'(out_fmv_w_x_i);
            default:      sel_data_c = '0;
        endcase
    end

endmodule

// File: rtl/falu_cmd_responder.sv
// Responder for one FALU op at a time: request handshake, fixed-latency wait, tagged response.
// Optional RSP_PAR output (XOR of RSP_DATA) when FALU_RSP_PARITY_EN is defined.
module falu_cmd_responder
    import falu_pkg::*;
#(
    parameter int unsigned OP_DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH     = 4,
    parameter int unsigned FALU_LAT      = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [FUNC_W-1:0]        REQ_FUNC,
    input  logic [OP_DATA_WIDTH-1:0] REQ_A,
    input  logic [OP_DATA_WIDTH-1:0] REQ_B,
    input  logic [OP_DATA_WIDTH-1:0] REQ_C,
    input  logic [63:0]              REQ_A_64,
    input  logic [TAG_WIDTH-1:0]     REQ_TAG,
    output logic [OP_DATA_WIDTH-1:0] FALU_A,
    output logic [OP_DATA_WIDTH-1:0] FALU_B,
    output logic [OP_DATA_WIDTH-1:0] FALU_C,
    output logic [63:0]              FALU_A_64,
    output logic [FUNC_W-1:0]        FALU_FUNC,
    input  logic [OP_DATA_WIDTH-1:0] OUT_FMADD,
    input  logic [OP_DATA_WIDTH-1:0] OUT_FNMADD,
    input  logic [OP_DATA_WIDTH-1:0] OUT_FMSUB,
    input  logic [OP_DATA_WIDTH-1:0] OUT_FNMSUB,
    input  logic [OP_DATA_WIDTH-1:0] OUT_ADD,
    input  logic [OP_DATA_WIDTH-1:0] OUT_SUB,
    input  logic [OP_DATA_WIDTH-1:0] OUT_MUL,
    input  logic [OP_DATA_WIDTH-1:0] OUT_DIV,
    input  logic [OP_DATA_WIDTH-1:0] OUT_FSQRT,
    input  logic [OP_DATA_WIDTH-1:0] OUT_FSGNJ,
    input  logic [OP_DATA_WIDTH-1:0] OUT_FSGNJN,
    input  logic [OP_DATA_WIDTH-1:0] OUT_FSGNJX,
    input  logic [OP_DATA_WIDTH-1:0] OUT_MIN_MAX,
    input  logic [OP_DATA_WIDTH-1:0] OUT_FMV_W_X,
    input  logic [CLS_W-1:0]         OUT_CLASS,
    input  logic [63:0]              OUT_FMV_X_W,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [RSP_W-1:0]         RSP_DATA,
    output logic [TAG_WIDTH-1:0]     RSP_TAG,
`ifdef FALU_RSP_PARITY_EN
    output logic                     RSP_PAR,
`endif
    output logic                     RSP_ERR
);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [RSP_W-1:0]         rsp_data_q, rsp_data_d;
    logic [TAG_WIDTH-1:0]     rsp_tag_q, rsp_tag_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [OP_DATA_WIDTH-1:0] falu_a_q, falu_a_d, falu_b_q, falu_b_d, falu_c_q, falu_c_d;
    logic [63:0]              falu_a64_q, falu_a64_d;
    logic [FUNC_W-1:0]        falu_func_q, falu_func_d;
    logic                     rsp_par_q, rsp_par_d;
    logic [RSP_W-1:0]         sel_data_c;

    falu_result_mux #(.OP_W(OP_DATA_WIDTH)) u_result_mux (
        .func_i        (falu_func_q),
        .out_fmadd_i   (OUT_FMADD),
        .out_fnmadd_i  (OUT_FNMADD),
        .out_fmsub_i   (OUT_FMSUB),
        .out_fnmsub_i  (OUT_FNMSUB),
        .out_add_i     (OUT_ADD),
        .out_sub_i     (OUT_SUB),
        .out_mul_i     (OUT_MUL),
        .out_div_i     (OUT_DIV),
        .out_fsqrt_i   (OUT_FSQRT),
        .out_fsgnj_i   (OUT_FSGNJ),
        .out_fsgnjn_i  (OUT_FSGNJN),
        .out_fsgnjx_i  (OUT_FSGNJX),
        .out_min_max_i (OUT_MIN_MAX),
        .out_fmv_w_x_i (OUT_FMV_W_X),
        .out_class_i   (OUT_CLASS),
        .out_fmv_x_w_i (OUT_FMV_X_W),
        .sel_data_c    (sel_data_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
            falu_a_q    <= '0;
            falu_b_q    <= '0;
            falu_c_q    <= '0;
            falu_a64_q  <= '0;
            falu_func_q <= '0;
            rsp_par_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            falu_a_q    <= falu_a_d;
            falu_b_q    <= falu_b_d;
            falu_c_q    <= falu_c_d;
            falu_a64_q  <= falu_a64_d;
            falu_func_q <= falu_func_d;
            rsp_par_q   <= rsp_par_d;
        end
    end

    // Illegal codes skip the wait and answer with an error on the next cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        falu_a_d    = falu_a_q;
        falu_b_d    = falu_b_q;
        falu_c_d    = falu_c_q;
        falu_a64_d  = falu_a64_q;
        falu_func_d = falu_func_q;
        case (state_q)
            IDLE: begin
                if (REQ_VALID && req_ready_q) begin
                    falu_a_d    = REQ_A;
                    falu_b_d    = REQ_B;
                    falu_c_d    = REQ_C;
                    falu_a64_d  = REQ_A_64;
                    falu_func_d = REQ_FUNC;
                    rsp_tag_d   = REQ_TAG;
                    cnt_d       = CNT_W'(FALU_LAT);
                    if (func_is_legal(REQ_FUNC)) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    rsp_data_d = sel_data_c;
                    rsp_err_d  = 1'b0;
                end
            end
            RESP: begin
                if (RSP_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        rsp_par_d   = ^rsp_data_d;
    end

    assign REQ_READY = req_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_TAG   = rsp_tag_q;
    assign RSP_ERR   = rsp_err_q;
    assign FALU_A    = falu_a_q;
    assign FALU_B    = falu_b_q;
    assign FALU_C    = falu_c_q;
    assign FALU_A_64 = falu_a64_q;
    assign FALU_FUNC = falu_func_q;

`ifdef FALU_RSP_PARITY_EN
    assign RSP_PAR = rsp_par_q;
`else
    logic unused_par;
    assign unused_par = rsp_par_q;
`endif

endmodule

// File: tb/tb_falu_cmd_responder.sv
// Randomized self-checking bench for falu_cmd_responder with a behavioural FALU stub and reference model.
module tb_falu_cmd_responder;

    localparam int unsigned LAT = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID, REQ_READY;
    logic [4:0]  REQ_FUNC;
    logic [31:0] REQ_A, REQ_B, REQ_C;
    logic [63:0] REQ_A_64;
    logic [3:0]  REQ_TAG;
    logic [31:0] FALU_A, FALU_B, FALU_C;
    logic [63:0] FALU_A_64;
    logic [4:0]  FALU_FUNC;
    logic [31:0] OUT_FMADD, OUT_FNMADD, OUT_FMSUB, OUT_FNMSUB, OUT_ADD, OUT_SUB, OUT_MUL, OUT_DIV;
    logic [31:0] OUT_FSQRT, OUT_FSGNJ, OUT_FSGNJN, OUT_FSGNJX, OUT_MIN_MAX, OUT_FMV_W_X;
    logic [9:0]  OUT_CLASS;
    logic [63:0] OUT_FMV_X_W;
    logic        RSP_VALID, RSP_READY, RSP_ERR;
    logic [63:0] RSP_DATA;
    logic [3:0]  RSP_TAG;
`ifdef FALU_RSP_PARITY_EN
    logic        RSP_PAR;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] last_rsp;

    always #5 CLK = ~CLK;

    // Stand-in FALU: distinct, operand-dependent value per function, plus the known FMSUB vector.
    function automatic logic [31:0] stub32(input int k, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        if (k == 2 && a == 32'h40866666 && b == 32'h404CCCCC && c == 32'h404CCCCC)
            return 32'h4123D708;
        return (a ^ {b[15:0], b[31:16]}) + c + 32'(k) * 32'h01000193;
    endfunction

    function automatic logic [9:0] stub10(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return 10'(stub32(13, a, b, c));
    endfunction

    function automatic logic [63:0] stub64(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {stub32(14, a, b, c), stub32(14, b, a, c)};
    endfunction

    assign OUT_FMADD   = stub32(0,  FALU_A, FALU_B, FALU_C);
    assign OUT_FNMADD  = stub32(1,  FALU_A, FALU_B, FALU_C);
    assign OUT_FMSUB   = stub32(2,  FALU_A, FALU_B, FALU_C);
    assign OUT_FNMSUB  = stub32(3,  FALU_A, FALU_B, FALU_C);
    assign OUT_ADD     = stub32(4,  FALU_A, FALU_B, FALU_C);
    assign OUT_SUB     = stub32(5,  FALU_A, FALU_B, FALU_C);
    assign OUT_MUL     = stub32(6,  FALU_A, FALU_B, FALU_C);
    assign OUT_DIV     = stub32(7,  FALU_A, FALU_B, FALU_C);
    assign OUT_FSQRT   = stub32(8,  FALU_A, FALU_B, FALU_C);
    assign OUT_FSGNJ   = stub32(9,  FALU_A, FALU_B, FALU_C);
    assign OUT_FSGNJN  = stub32(10, FALU_A, FALU_B, FALU_C);
    assign OUT_FSGNJX  = stub32(11, FALU_A, FALU_B, FALU_C);
    assign OUT_MIN_MAX = stub32(12, FALU_A, FALU_B, FALU_C);
    assign OUT_CLASS   = stub10(FALU_A, FALU_B, FALU_C);
    assign OUT_FMV_X_W = stub64(FALU_A, FALU_B, FALU_C);
    assign OUT_FMV_W_X = stub32(15, FALU_A_64[31:0], FALU_A_64[63:32], FALU_C);

    falu_cmd_responder #(.OP_DATA_WIDTH(32), .TAG_WIDTH(4), .FALU_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_FUNC(REQ_FUNC),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_C(REQ_C), .REQ_A_64(REQ_A_64), .REQ_TAG(REQ_TAG),
        .FALU_A(FALU_A), .FALU_B(FALU_B), .FALU_C(FALU_C), .FALU_A_64(FALU_A_64), .FALU_FUNC(FALU_FUNC),
        .OUT_FMADD(OUT_FMADD), .OUT_FNMADD(OUT_FNMADD), .OUT_FMSUB(OUT_FMSUB), .OUT_FNMSUB(OUT_FNMSUB),
        .OUT_ADD(OUT_ADD), .OUT_SUB(OUT_SUB), .OUT_MUL(OUT_MUL), .OUT_DIV(OUT_DIV), .OUT_FSQRT(OUT_FSQRT),
        .OUT_FSGNJ(OUT_FSGNJ), .OUT_FSGNJN(OUT_FSGNJN), .OUT_FSGNJX(OUT_FSGNJX), .OUT_MIN_MAX(OUT_MIN_MAX),
        .OUT_FMV_W_X(OUT_FMV_W_X), .OUT_CLASS(OUT_CLASS), .OUT_FMV_X_W(OUT_FMV_X_W),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_TAG(RSP_TAG),
`ifdef FALU_RSP_PARITY_EN
        .RSP_PAR(RSP_PAR),
`endif
        .RSP_ERR(RSP_ERR)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: which FALU result the function code returns, and how it is widened.
    function automatic logic [63:0] ref_rsp(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [63:0] a64);
        if (f > 5'd15) return 64'd0;
        if (f == 5'd13) return {54'd0, stub10(a, b, c)};
        if (f == 5'd14) return stub64(a, b, c);
        if (f == 5'd15) return {32'd0, stub32(15, a64[31:0], a64[63:32], c)};
        return {32'd0, stub32(int'(f), a, b, c)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic scramble_req();
        REQ_FUNC = 5'($urandom);
        REQ_A    = $urandom;
        REQ_B    = $urandom;
        REQ_C    = $urandom;
        REQ_A_64 = {$urandom, $urandom};
        REQ_TAG  = 4'($urandom);
    endtask

    task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [63:0] a64, input logic [3:0] tag, input int bp);
        logic [63:0] exp_data;
        logic        exp_err;
        int          lat;
        int          waited;
        exp_data = ref_rsp(f, a, b, c, a64);
        exp_err  = (f > 5'd15);
        waited   = 0;
        while (!REQ_READY && waited < 20) begin
            tick();
            waited++;
        end
        if (!REQ_READY) begin
            check_eq("req_ready_timeout", 64'(REQ_READY), 64'd1);
            return;
        end
        REQ_VALID = 1'b1;
        REQ_FUNC = f; REQ_A = a; REQ_B = b; REQ_C = c; REQ_A_64 = a64; REQ_TAG = tag;
        tick();
        REQ_VALID = 1'b0;
        scramble_req();
        check_eq("falu_func", 64'(FALU_FUNC), 64'(f));
        check_eq("falu_a", 64'(FALU_A), 64'(a));
        check_eq("falu_a64", FALU_A_64, a64);
        check_eq("req_ready_busy", 64'(REQ_READY), 64'd0);
        lat = 1;
        while (!RSP_VALID && lat < 40) begin
            tick();
            lat++;
        end
        check_eq("rsp_latency", 64'(lat), exp_err ? 64'd1 : 64'(LAT + 1));
        check_eq("rsp_data", RSP_DATA, exp_data);
        check_eq("rsp_tag", 64'(RSP_TAG), 64'(tag));
        check_eq("rsp_err", 64'(RSP_ERR), 64'(exp_err));
`ifdef FALU_RSP_PARITY_EN
        check_eq("rsp_par", 64'(RSP_PAR), 64'(^exp_data));
`endif
        last_rsp = RSP_DATA;
        for (int i = 0; i < bp; i++) begin
            tick();
            check_eq("bp_valid", 64'(RSP_VALID), 64'd1);
            check_eq("bp_data", RSP_DATA, exp_data);
            check_eq("bp_tag", 64'(RSP_TAG), 64'(tag));
            check_eq("bp_req_ready", 64'(REQ_READY), 64'd0);
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        check_eq("rsp_done_valid", 64'(RSP_VALID), 64'd0);
        check_eq("idle_req_ready", 64'(REQ_READY), 64'd1);
        check_eq("falu_hold", 64'(FALU_B), 64'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] f;
        RST = 1'b1; REQ_VALID = 1'b0; RSP_READY = 1'b0;
        scramble_req();
        tick();
        tick();
        check_eq("rst_req_ready", 64'(REQ_READY), 64'd0);
        check_eq("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
        check_eq("rst_rsp_data", RSP_DATA, 64'd0);
        check_eq("rst_rsp_tag_err", {RSP_TAG, RSP_ERR}, 64'd0);
        check_eq("rst_falu", {FALU_FUNC, FALU_A}, 64'd0);
        RST = 1'b0;
        tick();
        check_eq("post_rst_ready", 64'(REQ_READY), 64'd1);

        do_op(5'd2, 32'h40866666, 32'h404CCCCC, 32'h404CCCCC, 64'd0, 4'h3, 0);
        check_eq("fmsub_vector", last_rsp, 64'h00000000_4123D708);
        do_op(5'd4, 32'h40CCCCCC, 32'hBF000000, 32'h0, 64'd0, 4'hA, 0);
        do_op(5'b10011, $urandom, $urandom, $urandom, {$urandom, $urandom}, 4'h5, 0);
        check_eq("illegal_falu_func", 64'(FALU_FUNC), 64'd19);
        do_op(5'd6, $urandom, $urandom, $urandom, {$urandom, $urandom}, 4'h7, 5);
        do_op(5'd14, 32'hFFFF0000, 32'h8000_0001, 32'h1234_5678, 64'd0, 4'hE, 1);
        do_op(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 4'hD, 0);
        check_eq("class_upper_zero", last_rsp >> 10, 64'd0);
        do_op(5'd15, $urandom, $urandom, $urandom, 64'hDEAD_BEEF_CAFE_F00D, 4'h1, 2);

        // Reset while the op is waiting on the FALU must drop it silently.
        REQ_VALID = 1'b1; REQ_FUNC = 5'd7; REQ_TAG = 4'h9;
        tick();
        REQ_VALID = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_eq("rst_wait_valid", 64'(RSP_VALID), 64'd0);
        check_eq("rst_wait_falu_func", 64'(FALU_FUNC), 64'd0);
        tick();
        check_eq("rst_wait_ready", 64'(REQ_READY), 64'd1);
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            check_eq("rst_wait_no_rsp", 64'(RSP_VALID), 64'd0);
            tick();
        end

        for (int n = 0; n < 40; n++) begin
            f = ($urandom_range(0, 3) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 15));
            do_op(f, $urandom, $urandom, $urandom, {$urandom, $urandom}, 4'($urandom),
                  int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
